// File: rtl/draw_commit_scheduler.sv
// draw_commit_scheduler: round-robin sequencer feeding draw words through the converter
// and committing converted records into free object-table slots.
module draw_commit_scheduler #(
    parameter int NUM_SLOTS      = 8,
    parameter int SLOT_W         = $clog2(NUM_SLOTS),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [1:0]                 req_valid_in,
    input  logic [1:0][86:0]           req_props_in,
    output logic [1:0]                 req_ready_out,
    output logic                       conv_valid_out,
    output logic [86:0]                conv_props_out,
    input  logic                       conv_valid_in,
    input  logic                       conv_is_static_in,
    input  logic [1:0]                 conv_id_in,
    input  logic [47:0]                conv_params_in,
    input  logic [15:0]                conv_pos_x_in,
    input  logic [15:0]                conv_pos_y_in,
    input  logic [15:0]                conv_vel_x_in,
    input  logic [15:0]                conv_vel_y_in,
    output logic                       wr_en_out,
    output logic [SLOT_W-1:0]          wr_addr_out,
    output logic [114:0]               wr_data_out,
    input  logic                       free_in,
    input  logic [SLOT_W-1:0]          free_addr_in,
    output logic [NUM_SLOTS-1:0]       occupancy_out,
    output logic                       full_out,
    output logic                       busy_out,
    output logic                       err_timeout_out,
    output logic                       err_bad_id_out,
    output logic                       err_bad_free_out
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    state_t                state_q, state_d;
    logic [86:0]           props_q, props_d;
    logic                  last_q, last_d;
    logic [SLOT_W-1:0]     alloc_q, alloc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [114:0]          wr_data_q, wr_data_d;
    logic [NUM_SLOTS-1:0]  occ_q, occ_d;
    logic                  err_to_q, err_to_d;
    logic                  err_id_q, err_id_d;
    logic                  err_free_q, err_free_d;
    logic                  grant, win, bad_id, timeout, free_ok;
    logic [SLOT_W-1:0]     free_slot;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            props_q    <= '0;
            last_q     <= 1'b1;
            alloc_q    <= '0;
            cnt_q      <= '0;
            wr_data_q  <= '0;
            occ_q      <= '0;
            err_to_q   <= 1'b0;
            err_id_q   <= 1'b0;
            err_free_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            props_q    <= props_d;
            last_q     <= last_d;
            alloc_q    <= alloc_d;
            cnt_q      <= cnt_d;
            wr_data_q  <= wr_data_d;
            occ_q      <= occ_d;
            err_to_q   <= err_to_d;
            err_id_q   <= err_id_d;
            err_free_q <= err_free_d;
        end
    end

    // Arbitration, slot search and datapath next-values; allocation always sees the pre-free bitmap.
    always_comb begin
        grant     = state_q == IDLE && |req_valid_in && !(&occ_q);
        win       = &req_valid_in ? ~last_q : req_valid_in[1];
        bad_id    = req_props_in[win][85:84] == 2'b00;
        timeout   = state_q == WAIT && !conv_valid_in && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
        free_ok   = free_in && occ_q[free_addr_in];
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!occ_q[i]) free_slot = SLOT_W'(i);
        props_d    = grant ? req_props_in[win] : props_q;
        last_d     = grant ? win : last_q;
        alloc_d    = grant ? free_slot : alloc_q;
        cnt_d      = state_q == WAIT ? cnt_q + CNT_W'(1) : '0;
        wr_data_d  = state_q == WAIT && conv_valid_in
                   ? {conv_is_static_in, conv_id_in, conv_params_in,
                      conv_pos_x_in, conv_pos_y_in, conv_vel_x_in, conv_vel_y_in}
                   : wr_data_q;
        occ_d      = occ_q;
        if (free_ok) occ_d[free_addr_in] = 1'b0;
        if (state_q == WRITE) occ_d[alloc_q] = 1'b1;
        err_to_d   = timeout;
        err_id_d   = grant && bad_id;
        err_free_d = free_in && !occ_q[free_addr_in];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = grant && !bad_id ? ISSUE : IDLE;
            ISSUE: state_d = WAIT;
            WAIT:  state_d = conv_valid_in ? WRITE : (timeout ? IDLE : WAIT);
            WRITE: state_d = IDLE;
        endcase
    end

    // Ready is combinational so a waiting request is accepted in its first IDLE cycle.
    always_comb begin
        req_ready_out    = rst_in ? {grant && win, grant && !win} : 2'b00;
        conv_valid_out   = state_q == ISSUE || state_q == WAIT;
        conv_props_out   = props_q;
        wr_en_out        = state_q == WRITE;
        wr_addr_out      = alloc_q;
        wr_data_out      = wr_data_q;
        occupancy_out    = occ_q;
        full_out         = &occ_q;
        busy_out         = state_q != IDLE;
        err_timeout_out  = err_to_q;
        err_bad_id_out   = err_id_q;
        err_bad_free_out = err_free_q;
    end
endmodule

// File: tb/tb_draw_commit_scheduler.sv
// tb_draw_commit_scheduler: directed vectors with hand-computed expectations.
module tb_draw_commit_scheduler;
    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic [1:0]       req_valid_in = '0;
    logic [1:0][86:0] req_props_in = '0;
    logic [1:0]       req_ready_out;
    logic             conv_valid_out;
    logic [86:0]      conv_props_out;
    logic             conv_valid_in = 1'b0;
    logic             conv_is_static_in = 1'b0;
    logic [1:0]       conv_id_in = '0;
    logic [47:0]      conv_params_in = '0;
    logic [15:0]      conv_pos_x_in = '0, conv_pos_y_in = '0, conv_vel_x_in = '0, conv_vel_y_in = '0;
    logic             wr_en_out;
    logic [2:0]       wr_addr_out;
    logic [114:0]     wr_data_out;
    logic             free_in = 1'b0;
    logic [2:0]       free_addr_in = '0;
    logic [7:0]       occupancy_out;
    logic             full_out, busy_out, err_timeout_out, err_bad_id_out, err_bad_free_out;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [86:0]      p_line, p_circ;
    logic [114:0]     rec;

    draw_commit_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_props_in(req_props_in), .req_ready_out(req_ready_out),
        .conv_valid_out(conv_valid_out), .conv_props_out(conv_props_out),
        .conv_valid_in(conv_valid_in), .conv_is_static_in(conv_is_static_in), .conv_id_in(conv_id_in),
        .conv_params_in(conv_params_in), .conv_pos_x_in(conv_pos_x_in), .conv_pos_y_in(conv_pos_y_in),
        .conv_vel_x_in(conv_vel_x_in), .conv_vel_y_in(conv_vel_y_in),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
        .free_in(free_in), .free_addr_in(free_addr_in),
        .occupancy_out(occupancy_out), .full_out(full_out), .busy_out(busy_out),
        .err_timeout_out(err_timeout_out), .err_bad_id_out(err_bad_id_out),
        .err_bad_free_out(err_bad_free_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        cyc();
        rst_in = 1'b1;
    endtask

    function automatic logic [86:0] props(input logic st, input logic [1:0] id,
                                          input logic [20:0] a, input logic [20:0] b);
        return {st, id, a, b, 21'd0, 21'd0};
    endfunction

    function automatic logic [106:0] outs_flat();
        return {req_ready_out, conv_valid_out, conv_props_out, wr_en_out, wr_addr_out,
                occupancy_out, full_out, busy_out, err_timeout_out, err_bad_id_out, err_bad_free_out};
    endfunction

    initial begin
        // reset state, with a request pending that must not be acknowledged
        req_valid_in = 2'b01;
        #12;
        check("rst_outs", outs_flat(), '0);
        check("rst_wr_data", wr_data_out, '0);
        req_valid_in = 2'b00;
        cyc();
        rst_in = 1'b1;

        // single line, converter answers at once
        p_line = props(1'b0, 2'b10, {11'd100, 10'd50}, {11'd200, 10'd80});
        conv_valid_in = 1'b1; conv_id_in = 2'b10; conv_params_in = 48'h123456789abc;
        conv_pos_x_in = 16'd100; conv_pos_y_in = 16'd50; conv_vel_x_in = 16'd3; conv_vel_y_in = 16'hfffe;
        rec = {1'b0, 2'b10, 48'h123456789abc, 16'd100, 16'd50, 16'd3, 16'hfffe};
        req_props_in[0] = p_line; req_valid_in = 2'b01;
        #3 check("t1_ready", req_ready_out, 2'b01);
        check("t1_idle", busy_out, 1'b0);
        cyc(); req_valid_in = 2'b00;
        #3 check("t1_issue_valid", conv_valid_out, 1'b1);
        check("t1_issue_props", conv_props_out, p_line);
        check("t1_no_bad_id", err_bad_id_out, 1'b0);
        cyc();
        #3 check("t1_wait_valid", conv_valid_out, 1'b1);
        check("t1_wait_noen", wr_en_out, 1'b0);
        cyc();
        #3 check("t1_wr_en", wr_en_out, 1'b1);
        check("t1_wr_addr", wr_addr_out, 3'd0);
        check("t1_wr_data", wr_data_out, rec);
        check("t1_write_conv_low", conv_valid_out, 1'b0);
        cyc();
        #3 check("t1_occ", occupancy_out, 8'h01);
        check("t1_wr_done", wr_en_out, 1'b0);

        // both requesters continuously valid: grants alternate from requester 0
        cyc(); do_reset();
        req_props_in[0] = props(1'b0, 2'b01, 21'd7, 21'd9);
        req_props_in[1] = props(1'b0, 2'b11, 21'd5, 21'd6);
        for (int c = 0; c < 16; c++) begin
            req_valid_in = 2'b11;
            #3 check("t2_ready", req_ready_out, c % 4 != 0 ? 2'b00 : ((c / 4) % 2 == 0 ? 2'b01 : 2'b10));
            check("t2_wr_en", wr_en_out, c % 4 == 3);
            if (c % 4 == 3) check("t2_wr_addr", wr_addr_out, c / 4);
            cyc();
        end
        req_valid_in = 2'b00;
        #3 check("t2_occ", occupancy_out, 8'h0F);

        // converter never answers: abort after the wait budget
        cyc();
        conv_valid_in = 1'b0;
        req_props_in[0] = props(1'b1, 2'b01, 21'd33, 21'd44); req_valid_in = 2'b01;
        #3 check("t3_ready", req_ready_out, 2'b01);
        cyc(); req_valid_in = 2'b00;
        for (int c = 1; c <= 67; c++) begin
            #3 check("t3_err_timeout", err_timeout_out, c == 66);
            check("t3_conv_valid", conv_valid_out, c <= 65);
            check("t3_no_wr", wr_en_out, 1'b0);
            cyc();
        end
        #3 check("t3_occ", occupancy_out, 8'h0F);
        check("t3_idle", busy_out, 1'b0);

        // fill remaining slots, stall on full, free slot 5 and refill it
        cyc();
        conv_valid_in = 1'b1;
        req_props_in[0] = p_line;
        for (int c = 0; c < 16; c++) begin
            req_valid_in = 2'b01;
            #3 check("t4_ready", req_ready_out, c % 4 == 0 ? 2'b01 : 2'b00);
            if (c % 4 == 3) check("t4_wr_addr", wr_addr_out, 4 + c / 4);
            cyc();
        end
        for (int c = 0; c < 4; c++) begin
            #3 check("t4_full", full_out, 1'b1);
            check("t4_stall", req_ready_out, 2'b00);
            cyc();
        end
        free_in = 1'b1; free_addr_in = 3'd5;
        #3 check("t4_free_cycle_full", full_out, 1'b1);
        check("t4_free_cycle_stall", req_ready_out, 2'b00);
        cyc(); free_in = 1'b0;
        #3 check("t4_unfull", full_out, 1'b0);
        check("t4_occ_freed", occupancy_out, 8'hDF);
        check("t4_regrant", req_ready_out, 2'b01);
        cyc(); req_valid_in = 2'b00;
        cyc(); cyc();
        #3 check("t4_refill_en", wr_en_out, 1'b1);
        check("t4_refill_addr", wr_addr_out, 3'd5);
        cyc();
        #3 check("t4_occ_full", occupancy_out, 8'hFF);

        // id 00 request and bad free
        cyc(); do_reset();
        req_props_in[0] = props(1'b0, 2'b00, 21'd1, 21'd2); req_valid_in = 2'b01;
        #3 check("t5_ready", req_ready_out, 2'b01);
        cyc(); req_valid_in = 2'b00;
        #3 check("t5_err_bad_id", err_bad_id_out, 1'b1);
        check("t5_conv_low", conv_valid_out, 1'b0);
        check("t5_idle", busy_out, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #3 check("t5_no_activity", {wr_en_out, conv_valid_out, err_bad_id_out}, 3'b000);
        end
        cyc(); free_in = 1'b1; free_addr_in = 3'd3;
        cyc(); free_in = 1'b0;
        #3 check("t5_err_bad_free", err_bad_free_out, 1'b1);
        check("t5_occ", occupancy_out, 8'h00);
        cyc();
        #3 check("t5_err_bad_free_pulse", err_bad_free_out, 1'b0);

        // reset in the middle of a conversion
        cyc();
        req_props_in[0] = p_line; req_valid_in = 2'b01;
        cyc(); req_valid_in = 2'b00;
        cyc(); cyc(); cyc();
        #3 check("t6_occ_pre", occupancy_out, 8'h01);
        conv_valid_in = 1'b0;
        cyc();
        req_props_in[0] = props(1'b1, 2'b01, 21'd12, 21'd34); req_valid_in = 2'b01;
        #3 check("t6_ready", req_ready_out, 2'b01);
        cyc(); req_valid_in = 2'b00;
        cyc();
        #2 check("t6_in_wait", conv_valid_out, 1'b1);
        rst_in = 1'b0;
        #1 check("t6_async_outs", outs_flat(), '0);
        check("t6_async_data", wr_data_out, '0);
        conv_valid_in = 1'b1;
        cyc(); rst_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #3 check("t6_no_write", {wr_en_out, occupancy_out}, 9'd0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
